// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter
// Shared-memory responder for the manycore. Each cycle it grants at most one
// core's shared load/store request and serves it from a word-addressed 32-bit
// array. Cores that request but are not granted are stalled.
//
// Configuration macro:
//   SHMEM_RR_EN  defined   -> round-robin arbitration using a registered pointer
//                undefined -> fixed priority, lowest core index wins
//
// Parameters:
//   NCORES  number of requesting cores (2..16)
//   AW      word-address width, array depth 2^AW words (AW <= 29)
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   req      per-core shared-access request
//   addr     per-core byte address, core i at [32i+31:32i]
//   wdata    per-core store data
//   rd       per-core read strobe (loads are served whenever granted)
//   wr       per-core write strobe
//   rdata    per-core load data, zero for non-granted cores
//   grant    one-hot grant, combinational
//   stall    req & ~grant, combinational
//   err      sticky out-of-range flag
//   acc_cnt  number of granted accesses, wrapping

module shared_mem_arbiter #(
    parameter int NCORES = 4,
    parameter int AW     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCORES-1:0]      req,
    input  logic [32*NCORES-1:0]   addr,
    input  logic [32*NCORES-1:0]   wdata,
    input  logic [NCORES-1:0]      rd,
    input  logic [NCORES-1:0]      wr,
    output logic [32*NCORES-1:0]   rdata,
    output logic [NCORES-1:0]      grant,
    output logic [NCORES-1:0]      stall,
    output logic                   err,
    output logic [31:0]            acc_cnt
);

    localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;

    logic [31:0]       mem [2**AW];

    logic [31:0]       addr_a  [NCORES];
    logic [31:0]       wdata_a [NCORES];

    logic              found;
    logic [PW-1:0]     gidx;
    logic [PW-1:0]     idx_p;
    logic [31:0]       g_addr;
    logic [31:0]       g_wdata;
    logic              g_wr;
    logic              in_range;
    logic [AW-1:0]     g_index;
    logic [31:0]       g_rdata;
    logic              unused_bits;

`ifdef SHMEM_RR_EN
    logic [PW-1:0]     ptr;
`endif

    // Split the flat per-core buses into arrays so the winner can be selected
    // by index.
    always_comb begin
        for (int i = 0; i < NCORES; i++) begin
            addr_a[i]  = addr[32*i +: 32];
            wdata_a[i] = wdata[32*i +: 32];
        end
    end

    // Search for the first requester starting at the pointer (round-robin) or
    // at core 0 (fixed priority). Nothing is granted while reset is held.
    always_comb begin
        found   = 1'b0;
        gidx    = '0;
        idx_p   = '0;
        grant   = '0;
        g_addr  = '0;
        g_wdata = '0;
        g_wr    = 1'b0;
        for (int off = 0; off < NCORES; off++) begin
`ifdef SHMEM_RR_EN
            idx_p = PW'((int'(ptr) + off) % NCORES);
`else
            idx_p = PW'(off);
`endif
            if (!found && req[idx_p] && reset) begin
                found        = 1'b1;
                gidx         = idx_p;
                grant[idx_p] = 1'b1;
                g_addr       = addr_a[idx_p];
                g_wdata      = wdata_a[idx_p];
                g_wr         = wr[idx_p];
            end
        end
    end

    // Any set bit above the word index lies outside the array.
    assign in_range    = ~|g_addr[31:AW+2];
    assign g_index     = g_addr[AW+1:2];
    assign g_rdata     = in_range ? mem[g_index] : 32'h0;
    assign stall       = reset ? (req & ~grant) : '0;

    // Byte offset bits and the read strobe never affect behaviour: a granted
    // access always returns the addressed word.
    assign unused_bits = ^{g_addr[1:0], rd};

    // Only the granted core sees load data; everyone else gets zero.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NCORES; i++) begin
            if (found && gidx == PW'(i)) begin
                rdata[32*i +: 32] = g_rdata;
            end
        end
    end

    // The array has no reset; found is already forced low during reset, so an
    // access interrupted by reset never writes. A combined read/write returns
    // the old word because the write lands only at the edge.
    always_ff @(posedge clk) begin
        if (found && g_wr && in_range) begin
            mem[g_index] <= g_wdata;
        end
    end

    // Access counter, sticky error flag and arbitration pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err     <= 1'b0;
            acc_cnt <= 32'h0;
`ifdef SHMEM_RR_EN
            ptr     <= '0;
`endif
        end else if (found) begin
            acc_cnt <= acc_cnt + 32'h1;
            if (!in_range) begin
                err <= 1'b1;
            end
`ifdef SHMEM_RR_EN
            ptr <= (int'(gidx) == NCORES - 1) ? '0 : gidx + 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// tb_shared_mem_arbiter
// Directed bench for shared_mem_arbiter with NCORES=4, AW=8. Inputs change on
// the falling edge; combinational outputs are checked 1 time unit later and
// registered outputs are checked in the step after the rising edge that
// updates them. Expected grant sequences follow SHMEM_RR_EN.

module tb_shared_mem_arbiter;

    localparam int NCORES = 4;
    localparam int AW     = 8;

    logic                  clk;
    logic                  reset;
    logic [NCORES-1:0]     req;
    logic [32*NCORES-1:0]  addr;
    logic [32*NCORES-1:0]  wdata;
    logic [NCORES-1:0]     rd;
    logic [NCORES-1:0]     wr;
    logic [32*NCORES-1:0]  rdata;
    logic [NCORES-1:0]     grant;
    logic [NCORES-1:0]     stall;
    logic                  err;
    logic [31:0]           acc_cnt;

    int checks = 0;
    int fails  = 0;

    shared_mem_arbiter #(.NCORES(NCORES), .AW(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .addr    (addr),
        .wdata   (wdata),
        .rd      (rd),
        .wr      (wr),
        .rdata   (rdata),
        .grant   (grant),
        .stall   (stall),
        .err     (err),
        .acc_cnt (acc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive request/strobe vectors for all cores at once.
    task automatic apply_stimulus(input logic [3:0] r, input logic [3:0] rdv, input logic [3:0] wrv);
        req = r;
        rd  = rdv;
        wr  = wrv;
    endtask

    // Set one core's address and store data.
    task automatic set_core(input int i, input logic [31:0] a, input logic [31:0] d);
        addr[32*i +: 32]  = a;
        wdata[32*i +: 32] = d;
    endtask

    function automatic logic [31:0] rdata_of(input int i);
        return rdata[32*i +: 32];
    endfunction

    logic [3:0] exp_grant [8];
    logic [3:0] exp_stall [8];

    initial begin
`ifdef SHMEM_RR_EN
        exp_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_stall = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
`else
        exp_grant = '{default: 4'b0001};
        exp_stall = '{default: 4'b1110};
`endif
        reset = 1'b0;
        addr  = '0;
        wdata = '0;
        apply_stimulus(4'b1111, 4'b1111, 4'b1111);

        // Reset held with every core requesting.
        repeat (3) @(negedge clk);
        #1;
        check_output("reset_grant", 32'(grant), 32'h0);
        check_output("reset_stall", 32'(stall), 32'h0);
        check_output("reset_err", 32'(err), 32'h0);
        check_output("reset_acc", acc_cnt, 32'h0);
        check_output("reset_rdata0", rdata_of(0), 32'h0);

        // Release reset; core 2 writes 0xDEADBEEF to 0x100.
        @(negedge clk);
        reset = 1'b1;
        addr  = '0;
        wdata = '0;
        set_core(2, 32'h0000_0100, 32'hDEAD_BEEF);
        apply_stimulus(4'b0100, 4'b0000, 4'b0100);
        #1;
        check_output("wr2_grant", 32'(grant), 32'h4);
        check_output("wr2_stall", 32'(stall), 32'h0);

        // Core 0 reads it back in the same cycle as its grant.
        @(negedge clk);
        set_core(0, 32'h0000_0100, 32'h0);
        apply_stimulus(4'b0001, 4'b0001, 4'b0000);
        #1;
        check_output("acc_after_wr2", acc_cnt, 32'd1);
        check_output("rd0_grant", 32'(grant), 32'h1);
        check_output("rd0_rdata", rdata_of(0), 32'hDEAD_BEEF);
        check_output("rd0_rdata2_zero", rdata_of(2), 32'h0);

        // Core 3 idle access (rd=wr=0): counted, and the pointer wraps to 0.
        @(negedge clk);
        set_core(3, 32'h0, 32'h0);
        apply_stimulus(4'b1000, 4'b0000, 4'b0000);
        #1;
        check_output("idle3_grant", 32'(grant), 32'h8);

        // All four cores requesting for eight cycles.
        addr  = '0;
        wdata = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            apply_stimulus(4'b1111, 4'b0000, 4'b0000);
            #1;
            if (k == 0) check_output("acc_before_burst", acc_cnt, 32'd3);
            check_output($sformatf("burst_grant_%0d", k), 32'(grant), 32'(exp_grant[k]));
            check_output($sformatf("burst_stall_%0d", k), 32'(stall), 32'(exp_stall[k]));
        end

        @(negedge clk);
        apply_stimulus(4'b0000, 4'b0000, 4'b0000);
        #1;
        check_output("acc_after_burst", acc_cnt, 32'd11);
        check_output("idle_grant", 32'(grant), 32'h0);

        // Core 0 writes a marker at word 0.
        @(negedge clk);
        set_core(0, 32'h0000_0000, 32'hA5A5_A5A5);
        apply_stimulus(4'b0001, 4'b0000, 4'b0001);

        // Core 1 out-of-range write that would alias word 0 if unchecked.
        @(negedge clk);
        set_core(1, 32'h0000_0400, 32'h1234_5678);
        apply_stimulus(4'b0010, 4'b0000, 4'b0010);
        #1;
        check_output("oor_grant", 32'(grant), 32'h2);
        check_output("oor_rdata1", rdata_of(1), 32'h0);
        check_output("oor_err_before", 32'(err), 32'h0);

        @(negedge clk);
        apply_stimulus(4'b0000, 4'b0000, 4'b0000);
        #1;
        check_output("oor_err_set", 32'(err), 32'h1);
        check_output("oor_acc", acc_cnt, 32'd13);

        @(negedge clk);
        set_core(0, 32'h0000_0000, 32'h0);
        apply_stimulus(4'b0001, 4'b0001, 4'b0000);
        #1;
        check_output("oor_no_write", rdata_of(0), 32'hA5A5_A5A5);
        check_output("oor_err_sticky", 32'(err), 32'h1);

        // Core 3 combined read/write returns the old word.
        @(negedge clk);
        set_core(3, 32'h0000_0008, 32'h0000_0005);
        apply_stimulus(4'b1000, 4'b0000, 4'b1000);

        @(negedge clk);
        set_core(3, 32'h0000_0008, 32'h0000_0009);
        apply_stimulus(4'b1000, 4'b1000, 4'b1000);
        #1;
        check_output("rw3_old", rdata_of(3), 32'h0000_0005);
        check_output("rw3_rdata0_zero", rdata_of(0), 32'h0);

        @(negedge clk);
        apply_stimulus(4'b1000, 4'b1000, 4'b0000);
        #1;
        check_output("rw3_new", rdata_of(3), 32'h0000_0009);

        // Core 0 writes a known value at 0x10.
        @(negedge clk);
        set_core(0, 32'h0000_0010, 32'h1111_1111);
        apply_stimulus(4'b0001, 4'b0000, 4'b0001);

        // Reset asserted during a write to 0x10: aborted, state cleared at once.
        @(negedge clk);
        set_core(0, 32'h0000_0010, 32'h0000_CAFE);
        apply_stimulus(4'b0001, 4'b0000, 4'b0001);
        #1;
        reset = 1'b0;
        #1;
        check_output("midrst_grant", 32'(grant), 32'h0);
        check_output("midrst_stall", 32'(stall), 32'h0);
        check_output("midrst_err", 32'(err), 32'h0);
        check_output("midrst_acc", acc_cnt, 32'h0);
        check_output("midrst_rdata0", rdata_of(0), 32'h0);

        @(negedge clk);
        reset = 1'b1;
        apply_stimulus(4'b0000, 4'b0000, 4'b0000);

        @(negedge clk);
        apply_stimulus(4'b0001, 4'b0001, 4'b0000);
        #1;
        check_output("midrst_no_write", rdata_of(0), 32'h1111_1111);
        check_output("post_rst_grant", 32'(grant), 32'h1);

        @(negedge clk);
        apply_stimulus(4'b0000, 4'b0000, 4'b0000);
        #1;
        check_output("post_rst_acc", acc_cnt, 32'd1);
        check_output("post_rst_err", 32'(err), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
